serial_word_assembler: RTL
==========================

SERIAL_WORD_ASSEMBLER -- requirements
Module: serial_word_assembler

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the assembled word width in bits (legal range 2..16).
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 means the first received bit ends in word[WIDTH-1], 0 means it ends in word[0].
REQ-003 SHALL have port clock, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port serial_data, input, 1 bit: incoming bit, taken from the upstream D-flip-flop stage.
REQ-006 SHALL have port serial_valid, input, 1 bit: serial_data is to be accepted at this edge.
REQ-007 SHALL have port clear, input, 1 bit: synchronous abort of the partial word.
REQ-008 SHALL have port word, output, WIDTH bits: the completed word.
REQ-009 SHALL have port word_valid, output, 1 bit: word holds an unconsumed value.
REQ-010 SHALL have port word_ready, input, 1 bit: the consumer accepts word.
REQ-011 SHALL have port bit_count, output, clog2(WIDTH+1) bits: number of bits held in the partial word.
REQ-012 SHALL have port overrun, output, 1 bit: sticky flag set when a completed word is lost.

Function
REQ-013 SHALL accept one bit per edge where serial_valid=1 and clear=0, and SHALL increment bit_count by 1.
REQ-014 SHALL, when MSB_FIRST=1, shift the partial register left with the new bit entering at bit 0; when MSB_FIRST=0, it SHALL shift right with the new bit entering at bit WIDTH-1.
REQ-015 SHALL treat the edge that accepts bit number WIDTH as completion: bit_count wraps to 0, and the assembled value (including that bit) is offered to the output buffer at the same edge.
REQ-016 SHALL implement an output-buffer FSM with two states: EMPTY (word_valid=0) and FULL (word_valid=1).
REQ-017 SHALL, in EMPTY on completion, load word and go to FULL; word_valid is therefore high the cycle after the last bit's edge (latency 1).
REQ-018 SHALL define a transfer as word_valid=1 and word_ready=1 at an edge; after a transfer without completion the FSM goes to EMPTY.
REQ-019 SHALL, when a transfer and a completion occur at the same edge, load the new word and stay in FULL, with no overrun.
REQ-020 SHALL, on completion in FULL without word_ready, keep the old word, drop the new word, and set overrun=1.
REQ-021 SHALL hold word stable whenever word_valid=1 and no transfer occurs.
REQ-022 SHALL, on clear=1, zero the partial register, bit_count and overrun; clear takes priority over a simultaneous serial_valid, and that bit is discarded.
REQ-023 SHALL leave the FSM state and word unaffected by clear, while a transfer in the same cycle still proceeds.
REQ-024 SHALL ignore serial_data when serial_valid=0.

Reset
REQ-025 SHALL, on reset_n=0, immediately force: word=0, word_valid=0 (EMPTY), bit_count=0, partial register=0, overrun=0.
REQ-026 SHALL, when reset is asserted mid-word or with a pending word, discard all data; no word_valid pulse follows reset release.
REQ-027 SHALL have reset release take effect synchronously at the first rising edge after reset_n=1.

Structure
REQ-028 SHALL take the FSM state encodings (EMPTY=0, FULL=1) and the default WIDTH from a shared include file guarded by ifndef/define.
REQ-029 SHALL build every storage bit from one sub-module, flip_flop_d_reset: a D flip-flop with enable and asynchronous active-low reset.
REQ-030 SHALL keep all next-state logic combinational outside flip_flop_d_reset, with no latches.

Verification
REQ-031 SHALL pass this scenario: WIDTH=8, MSB_FIRST=1, bits 1,0,1,1,0,0,1,0 on consecutive edges with word_ready=0 -> word=8'hB2 and word_valid=1 one cycle after the 8th bit, with bit_count=0.
REQ-032 SHALL pass this scenario: the same bits with MSB_FIRST=0 -> word=8'h4D.
REQ-033 SHALL pass this scenario: word pending with word_ready=0, then a second full word 8'hFF is sent -> word remains 8'hB2 and overrun=1; clear then sets overrun=0 while word_valid stays 1.
REQ-034 SHALL pass this scenario: word_ready=1 at the same edge as the next completion -> word updates to the new value, word_valid stays 1, overrun=0.
REQ-035 SHALL pass this scenario: 5 bits sent, then clear with serial_valid=1 at the same edge -> bit_count=0, and the next 8 bits form a clean word.
REQ-036 SHALL pass this scenario: reset_n driven low between clock edges after 3 bits with a word pending -> all outputs reach 0 before the next edge.

Source files
------------

// File: rtl/serial_word_assembler_pkg.sv
// Shared definitions for the serial word assembler: default width, output
// buffer state encoding and its next-state rule.
`ifndef SERIAL_WORD_ASSEMBLER_PKG_SV
`define SERIAL_WORD_ASSEMBLER_PKG_SV

package serial_word_assembler_pkg;

  localparam int DEFAULT_WIDTH     = 8;
  localparam int DEFAULT_MSB_FIRST = 1;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

  // A completion arriving together with a transfer refills the buffer, so FULL persists.
  function automatic buf_state_e next_buf_state(input buf_state_e cur,
                                                input logic       complete,
                                                input logic       transfer);
    buf_state_e nxt;
    nxt = cur;
    case (cur)
      BUF_EMPTY: if (complete) nxt = BUF_FULL;
      BUF_FULL:  if (transfer && !complete) nxt = BUF_EMPTY;
      default:   nxt = BUF_EMPTY;
    endcase
    return nxt;
  endfunction

endpackage

`endif

// File: rtl/flip_flop_d_reset.sv
// Storage primitive: D flip-flop bank with load enable and asynchronous
// active-low reset to zero.
module flip_flop_d_reset #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (enable) begin
      q <= d;
    end
  end

endmodule

// File: rtl/serial_word_assembler.sv
// Deserialises a bit stream into WIDTH-bit words and holds each completed word
// in a one-entry output buffer until the consumer takes it.
//
// Output handshake: a transfer happens at a rising edge where word_valid and
// word_ready are both 1; while word_valid is 1 and no transfer occurs, word is
// held stable and word_valid stays high.
module serial_word_assembler
  import serial_word_assembler_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MSB_FIRST = DEFAULT_MSB_FIRST
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       serial_data,
  input  logic                       serial_valid,
  input  logic                       clear,
  output logic [WIDTH-1:0]           word,
  output logic                       word_valid,
  input  logic                       word_ready,
  output logic [$clog2(WIDTH+1)-1:0] bit_count,
  output logic                       overrun,
  output buf_state_e                 buf_state
);

  localparam int                 CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] partial_d, partial_q;
  logic [WIDTH-1:0] word_d, word_q;
  logic [WIDTH-1:0] shifted;
  logic [CNT_W-1:0] count_d, count_q;
  buf_state_e       state_d, state_q;
  logic             state_bit_q;
  logic             overrun_d, overrun_q;
  logic             accept, complete, transfer, word_load;

  always_comb begin
    accept    = serial_valid && !clear;
    complete  = accept && (count_q == LAST_BIT);
    transfer  = (state_q == BUF_FULL) && word_ready;
    word_load = complete && ((state_q == BUF_EMPTY) || transfer);

    if (MSB_FIRST != 0) begin
      shifted = {partial_q[WIDTH-2:0], serial_data};
    end else begin
      shifted = {serial_data, partial_q[WIDTH-1:1]};
    end

    partial_d = partial_q;
    count_d   = count_q;
    if (clear) begin
      partial_d = '0;
      count_d   = '0;
    end else if (accept) begin
      partial_d = complete ? '0 : shifted;
      count_d   = complete ? '0 : count_q + CNT_W'(1);
    end

    word_d  = shifted;
    state_d = next_buf_state(state_q, complete, transfer);

    // A completion that cannot be loaded is the only way a word gets lost.
    overrun_d = overrun_q;
    if (clear) begin
      overrun_d = 1'b0;
    end else if (complete && !word_load) begin
      overrun_d = 1'b1;
    end
  end

  flip_flop_d_reset #(.WIDTH(WIDTH)) u_partial_ff (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (1'b1),
    .d       (partial_d),
    .q       (partial_q)
  );

  flip_flop_d_reset #(.WIDTH(CNT_W)) u_count_ff (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (1'b1),
    .d       (count_d),
    .q       (count_q)
  );

  flip_flop_d_reset #(.WIDTH(WIDTH)) u_word_ff (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (word_load),
    .d       (word_d),
    .q       (word_q)
  );

  flip_flop_d_reset #(.WIDTH(1)) u_state_ff (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (1'b1),
    .d       (state_d),
    .q       (state_bit_q)
  );

  flip_flop_d_reset #(.WIDTH(1)) u_overrun_ff (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (1'b1),
    .d       (overrun_d),
    .q       (overrun_q)
  );

  assign state_q    = buf_state_e'(state_bit_q);
  assign word       = word_q;
  assign word_valid = (state_q == BUF_FULL);
  assign bit_count  = count_q;
  assign overrun    = overrun_q;
  assign buf_state  = state_q;

endmodule
